seg7_scan_capture: RTL and testbench

//  Receiving end of a multiplexed 7-segment display bus.
//  - Samples the segment lines and one-hot digit-select lines.
//  - Waits for each digit to be stable, then decodes its segment pattern back to BCD.
//  - Assembles one complete frame of N_DIGITS digits.
//  - Hands the frame to downstream logic over a valid/ready handshake.

---
 rtl/seg7_scan_if.sv | 23 ++
 rtl/seg7_scan_capture.sv | 202 ++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Display-bus inputs and captured-frame outputs shared by seg7_scan_capture and its drivers.
interface seg7_scan_if #(
  parameter int N_DIGITS = 4
);
  logic [6:0]            seg_in;
  logic [N_DIGITS-1:0]   dig_sel;
  logic                  frame_ready;
  logic                  frame_valid;
  logic [4*N_DIGITS-1:0] bcd_out;
  logic [N_DIGITS-1:0]   blank_mask;
  logic [N_DIGITS-1:0]   err_mask;
  logic                  overrun;

  modport master (
    output seg_in, dig_sel, frame_ready,
    input  frame_valid, bcd_out, blank_mask, err_mask, overrun
  );

  modport slave (
    input  seg_in, dig_sel, frame_ready,
    output frame_valid, bcd_out, blank_mask, err_mask, overrun
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Scrapes a multiplexed 7-segment bus, decodes each settled digit and delivers whole frames.
// Optional macro HEX_DECODE_EN adds decoding of the A-F glyphs.
module seg7_scan_capture #(
  parameter int N_DIGITS   = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_CAP = CW'(SETTLE_CYC - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_DIGITS-1:0] sel_q, sel_d;
  logic [6:0]          seg_q, seg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                in_changed;
  logic                sel_onehot;
  logic                capture;
  logic                complete;
  logic                load;
  logic [5:0]          dec;

  logic [N_DIGITS-1:0]   captured;
  logic [4*N_DIGITS-1:0] stage_bcd;
  logic [N_DIGITS-1:0]   stage_blank;
  logic [N_DIGITS-1:0]   stage_err;

  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic [4*N_DIGITS-1:0] out_bcd_q, out_bcd_d;
  logic [N_DIGITS-1:0]   out_blank_q, out_blank_d;
  logic [N_DIGITS-1:0]   out_err_q, out_err_d;

  // Result packing: {err, blank, nibble}
  function automatic logic [5:0] decode(input logic [6:0] s);
    logic [5:0] r;
    r = 6'b10_0000;
    case (s)
      7'h7E:   r = {2'b00, 4'h0};
      7'h30:   r = {2'b00, 4'h1};
      7'h6D:   r = {2'b00, 4'h2};
      7'h79:   r = {2'b00, 4'h3};
      7'h33:   r = {2'b00, 4'h4};
      7'h5B:   r = {2'b00, 4'h5};
      7'h5F:   r = {2'b00, 4'h6};
      7'h70:   r = {2'b00, 4'h7};
      7'h7F:   r = {2'b00, 4'h8};
      7'h7B:   r = {2'b00, 4'h9};
      7'h00:   r = 6'b01_0000;
`ifdef HEX_DECODE_EN
      7'h77:   r = {2'b00, 4'hA};
      7'h1F:   r = {2'b00, 4'hB};
      7'h4E:   r = {2'b00, 4'hC};
      7'h3D:   r = {2'b00, 4'hD};
      7'h4F:   r = {2'b00, 4'hE};
      7'h47:   r = {2'b00, 4'hF};
`endif
      default: r = 6'b10_0000;
    endcase
    return r;
  endfunction

  // Change detection looks at the value about to be registered, so the FSM tracks the
  // input register in lock-step and capture lands exactly SETTLE_CYC-1 edges after a change.
  always_comb begin
    sel_d      = bus.dig_sel;
    seg_d      = bus.seg_in;
    in_changed = ({sel_d, seg_d} != {sel_q, seg_q});
    sel_onehot = $onehot(sel_d);
    if (in_changed) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_onehot) state_d = SETTLE;
      end
      SETTLE: begin
        if (!sel_onehot) begin
          state_d = IDLE;
        end else if (!in_changed && cnt_q >= CNT_CAP) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (sel_d != sel_q) state_d = sel_onehot ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      seg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dec = decode(seg_q);

  // sel_q is one-hot whenever capture fires, so it doubles as the per-digit write enable.
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic [3:0] stg_nib_q, stg_nib_d;
      logic       stg_blank_q, stg_blank_d;
      logic       stg_err_q, stg_err_d;
      logic       cap_q, cap_d;
      logic       wr;

      always_comb begin
        wr          = capture && sel_q[gi];
        stg_nib_d   = stg_nib_q;
        stg_blank_d = stg_blank_q;
        stg_err_d   = stg_err_q;
        cap_d       = (cap_q && !complete) || wr;
        if (wr) {stg_err_d, stg_blank_d, stg_nib_d} = dec;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stg_nib_q   <= '0;
          stg_blank_q <= 1'b0;
          stg_err_q   <= 1'b0;
          cap_q       <= 1'b0;
        end else begin
          stg_nib_q   <= stg_nib_d;
          stg_blank_q <= stg_blank_d;
          stg_err_q   <= stg_err_d;
          cap_q       <= cap_d;
        end
      end

      assign captured[gi]         = cap_q;
      assign stage_bcd[4*gi +: 4] = stg_nib_q;
      assign stage_blank[gi]      = stg_blank_q;
      assign stage_err[gi]        = stg_err_q;
    end
  endgenerate

  // A completed frame either replaces the output slot (free or being accepted) or is dropped.
  always_comb begin
    complete    = &captured;
    load        = complete && (!valid_q || bus.frame_ready);
    overrun_d   = complete && !load;
    valid_d     = load || (valid_q && !bus.frame_ready);
    out_bcd_d   = out_bcd_q;
    out_blank_d = out_blank_q;
    out_err_d   = out_err_q;
    if (load) begin
      out_bcd_d   = stage_bcd;
      out_blank_d = stage_blank;
      out_err_d   = stage_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      out_bcd_q   <= '0;
      out_blank_q <= '0;
      out_err_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      out_bcd_q   <= out_bcd_d;
      out_blank_q <= out_blank_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.frame_valid = valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.bcd_out     = out_bcd_q;
  assign bus.blank_mask  = out_blank_q;
  assign bus.err_mask    = out_err_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture (N_DIGITS=4, SETTLE_CYC=4): directed scans then random scans.
module tb_seg7_scan_capture;
  localparam int N = 4;
  localparam int S = 4;
`ifdef HEX_DECODE_EN
  localparam int N_GLYPHS = 16;
`else
  localparam int N_GLYPHS = 10;
`endif
  // Glyph table indexed by the value it displays.
  localparam logic [6:0] GLYPH [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  typedef struct packed {
    logic [4*N-1:0] bcd;
    logic [N-1:0]   blank;
    logic [N-1:0]   err;
  } frame_t;

  logic clk = 1'b0;
  logic rst;

  seg7_scan_if #(.N_DIGITS(N)) bus ();

  seg7_scan_capture #(.N_DIGITS(N), .SETTLE_CYC(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int     checks   = 0;
  int     errors   = 0;
  int     exp_ovr  = 0;
  int     seen_ovr = 0;
  int     m_frames = 0;
  frame_t exp_q[$];
  frame_t mon_got, mon_want;

  logic [3:0] m_nib   [N];
  logic       m_blank [N];
  logic       m_err   [N];
  bit         m_cap   [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Returns {err, blank, nibble} by table search over the glyph list.
  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    if (p == 7'h00) return 6'b01_0000;
    for (int i = 0; i < N_GLYPHS; i++) begin
      if (GLYPH[i] == p) return {2'b00, 4'(i)};
    end
    return 6'b10_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_complete();
    frame_t f;
    for (int i = 0; i < N; i++) begin
      f.bcd[4*i +: 4] = m_nib[i];
      f.blank[i]      = m_blank[i];
      f.err[i]        = m_err[i];
      m_cap[i]        = 1'b0;
    end
    m_frames++;
    if (exp_q.size() == 0 || bus.frame_ready) exp_q.push_back(f);
    else exp_ovr++;
  endtask

  // Drive digit d with pattern pat for n cycles; it is captured iff held for at least S cycles.
  task automatic scan(input int d, input logic [6:0] pat, input int n, input bit chk_lat);
    int         lat = -1;
    bit         all;
    logic [5:0] r;
    bus.dig_sel    = '0;
    bus.dig_sel[d] = 1'b1;
    bus.seg_in     = pat;
    if (n >= S) begin
      r          = ref_decode(pat);
      m_nib[d]   = r[3:0];
      m_blank[d] = r[4];
      m_err[d]   = r[5];
      m_cap[d]   = 1'b1;
      all = 1'b1;
      for (int i = 0; i < N; i++) if (!m_cap[i]) all = 1'b0;
      if (all) model_complete();
    end
    for (int i = 1; i <= n; i++) begin
      tick();
      if (chk_lat && lat < 0 && bus.frame_valid) lat = i;
    end
    if (chk_lat) check("latency", 32'(lat), 32'(S + 1));
  endtask

  task automatic gap(input int n);
    bus.dig_sel = '0;
    bus.seg_in  = 7'($urandom);
    repeat (n) tick();
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 50) begin
      tick();
      i++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   32'(bus.frame_valid), 32'(0));
    check({tag, "_bcd"},     32'(bus.bcd_out),     32'(0));
    check({tag, "_blank"},   32'(bus.blank_mask),  32'(0));
    check({tag, "_err"},     32'(bus.err_mask),    32'(0));
    check({tag, "_overrun"}, 32'(bus.overrun),     32'(0));
  endtask

  // Monitor: a frame is accepted at the edge following a negedge where valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && bus.overrun) seen_ovr++;
    if (!rst && bus.frame_valid && bus.frame_ready) begin
      checks++;
      mon_got = {bus.bcd_out, bus.blank_mask, bus.err_mask};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected actual bcd=%h blank=%b err=%b required no frame",
                 mon_got.bcd, mon_got.blank, mon_got.err);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          errors++;
          $display("FAIL frame actual bcd=%h blank=%b err=%b required bcd=%h blank=%b err=%b",
                   mon_got.bcd, mon_got.blank, mon_got.err,
                   mon_want.bcd, mon_want.blank, mon_want.err);
        end else begin
          $display("frame bcd=%h blank=%b err=%b", mon_got.bcd, mon_got.blank, mon_got.err);
        end
      end
    end
  end

  initial begin
    int steps;
    int prev;
    int d;
    int n;
    int goal;
    logic [6:0] p;

    rst             = 1'b1;
    bus.dig_sel     = '0;
    bus.seg_in      = '0;
    bus.frame_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_nib[i] = '0; m_blank[i] = 1'b0; m_err[i] = 1'b0; m_cap[i] = 1'b0;
    end
    tick();
    tick();
    check_all_zero("reset");
    rst             = 1'b0;
    bus.frame_ready = 1'b1;
    tick();

    // Basic frame 4321 with first-frame latency
    scan(0, 7'h30, 8, 1'b0);
    scan(1, 7'h6D, 8, 1'b0);
    scan(2, 7'h79, 8, 1'b0);
    scan(3, 7'h33, 8, 1'b1);
    gap(2);
    drain();
    check("t1_bcd", 32'(bus.bcd_out), 32'(16'h4321));

    // Digit 0 glitching must not be captured before it settles on 7E
    scan(1, 7'h5F, 6, 1'b0);
    scan(2, 7'h70, 6, 1'b0);
    scan(3, 7'h7F, 6, 1'b0);
    for (int i = 0; i < 4; i++) begin
      scan(0, 7'h30, 2, 1'b0);
      scan(0, 7'h7E, 2, 1'b0);
    end
    scan(0, 7'h7E, S + 2, 1'b0);
    gap(2);
    drain();
    check("t2_bcd", 32'(bus.bcd_out), 32'(16'h8760));

    // Blank and undecodable digits
    scan(0, 7'h7E, 6, 1'b0);
    scan(1, 7'h00, 6, 1'b0);
    scan(2, 7'h01, 6, 1'b0);
    scan(3, 7'h33, 6, 1'b0);
    gap(2);
    drain();
    check("t3_blank", 32'(bus.blank_mask), 32'(4'b0010));
    check("t3_err",   32'(bus.err_mask),   32'(4'b0100));

    // Backpressure: second frame dropped with one overrun
    bus.frame_ready = 1'b0;
    scan(0, 7'h30, 6, 1'b0);
    scan(1, 7'h6D, 6, 1'b0);
    scan(2, 7'h79, 6, 1'b0);
    scan(3, 7'h33, 6, 1'b0);
    scan(0, 7'h5B, 6, 1'b0);
    scan(1, 7'h5F, 6, 1'b0);
    scan(2, 7'h70, 6, 1'b0);
    scan(3, 7'h7F, 6, 1'b0);
    gap(2);
    check("t4_bcd_held", 32'(bus.bcd_out),     32'(16'h4321));
    check("t4_valid",    32'(bus.frame_valid), 32'(1));
    check("t4_overrun",  32'(seen_ovr),        32'(exp_ovr));
    bus.frame_ready = 1'b1;
    tick();
    tick();
    check("t4_valid_drop", 32'(bus.frame_valid), 32'(0));
    drain();

    // Reset mid-frame discards the partial frame
    scan(0, 7'h7E, 6, 1'b0);
    scan(1, 7'h30, 6, 1'b0);
    bus.dig_sel = '0;
    rst = 1'b1;
    #1;
    check_all_zero("t5_rst");
    for (int i = 0; i < N; i++) m_cap[i] = 1'b0;
    tick();
    check_all_zero("t5_rst_hold");
    rst = 1'b0;
    tick();
    scan(2, 7'h7B, 6, 1'b0);
    scan(3, 7'h7B, 6, 1'b0);
    scan(0, 7'h7B, 6, 1'b0);
    scan(1, 7'h7B, 6, 1'b0);
    gap(2);
    drain();
    check("t5_bcd", 32'(bus.bcd_out), 32'(16'h9999));

    // Hex glyph A on every digit
    for (int i = 0; i < N; i++) scan(i, 7'h77, 6, 1'b0);
    gap(2);
    drain();
`ifdef HEX_DECODE_EN
    check("t6_bcd", 32'(bus.bcd_out),  32'(16'hAAAA));
    check("t6_err", 32'(bus.err_mask), 32'(4'h0));
`else
    check("t6_bcd", 32'(bus.bcd_out),  32'(16'h0000));
    check("t6_err", 32'(bus.err_mask), 32'(4'hF));
`endif

    // Random scans: random digit order, repeats, short holds and gaps
    steps = 0;
    prev  = -1;
    goal  = m_frames + 20;
    while (m_frames < goal && steps < 2000) begin
      d = int'($urandom_range(0, N - 1));
      case ($urandom_range(0, 3))
        0, 1:    p = GLYPH[$urandom_range(0, 9)];
        2:       p = GLYPH[$urandom_range(10, 15)];
        default: p = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom);
      endcase
      if (d == prev || $urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 2)));
      n = int'($urandom_range(S - 1, S + 3));
      scan(d, p, n, 1'b0);
      prev = d;
      steps++;
    end
    gap(3);
    drain();
    check("overrun_total", 32'(seen_ovr), 32'(exp_ovr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
